// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_pkg
// Description : Shared types for the multi-channel PWM LED driver. Holds the
//               channel mode encodings, the mode field width and the breathe
//               direction type.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Width of the per-channel mode field on the configuration port
  localparam int LED_MODE_W = 2;

  // Channel operating modes
  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_PWM     = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  // Direction of the breathe level ramp
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_channel
// Description : One LED channel. Holds the host mode/duty registers, the
//               active (shadow) copies loaded at period wrap, the breathe
//               ramp state machine with its period divider, the duty compare
//               and the registered LED output.
//               Optional build macro LED_GAMMA_EN: the duty is squared and
//               scaled down ((d*d) >> PWM_WIDTH) into a register that tracks
//               the host duty register; the shadow load then takes the mode
//               and corrected duty from the registers, so a write must land
//               at least one cycle before the wrap to be picked up by it.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_WIDTH    = 16,
  parameter int BREATHE_DIV  = 64,
  parameter int BREATHE_STEP = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [PWM_WIDTH-1:0]  i_cnt,
  input  logic                  i_wrap,
  input  logic                  i_we,
  input  logic [LED_MODE_W-1:0] i_mode,
  input  logic [PWM_WIDTH-1:0]  i_duty,
  output logic                  o_led
);

  localparam int                 DIV_W      = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(BREATHE_DIV - 1);
  localparam logic [PWM_WIDTH:0] STEP_EXT   = (PWM_WIDTH + 1)'(BREATHE_STEP);
  localparam logic               OFF_LEVEL  = (ACTIVE_LOW != 0);

  led_mode_e              r_mode_reg;
  logic [PWM_WIDTH-1:0]   r_duty_reg;
  led_mode_e              r_mode_act;
  logic [PWM_WIDTH-1:0]   r_duty_act;
  led_mode_e              w_load_mode;
  logic [PWM_WIDTH-1:0]   w_load_duty;

  breathe_dir_e           r_dir;
  breathe_dir_e           w_dir_nxt;
  logic [PWM_WIDTH-1:0]   r_lvl;
  logic [PWM_WIDTH-1:0]   w_lvl_nxt;
  logic [DIV_W-1:0]       r_div;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [PWM_WIDTH:0]     w_lvl_up;
  logic [PWM_WIDTH:0]     w_lvl_dn;

  logic                   w_on;
  logic                   r_led;

  // Host-visible mode/duty registers, written by the decoded strobe
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mode_reg <= LED_OFF;
      r_duty_reg <= '0;
    end else if (i_we) begin
      r_mode_reg <= led_mode_e'(i_mode);
      r_duty_reg <= i_duty;
    end
  end

`ifdef LED_GAMMA_EN
  logic [PWM_WIDTH-1:0]   w_duty_src;
  logic [2*PWM_WIDTH-1:0] w_duty_sq;
  logic [PWM_WIDTH-1:0]   r_duty_gam;

  assign w_duty_src = i_we ? i_duty : r_duty_reg;
  assign w_duty_sq  = {{PWM_WIDTH{1'b0}}, w_duty_src} * {{PWM_WIDTH{1'b0}}, w_duty_src};

  // Gamma-corrected duty, kept in step with the host duty register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_duty_gam <= '0;
    end else begin
      r_duty_gam <= w_duty_sq[2*PWM_WIDTH-1:PWM_WIDTH];
    end
  end

  assign w_load_mode = r_mode_reg;
  assign w_load_duty = r_duty_gam;
`else
  // A write landing on the wrap cycle goes straight into the shadow load
  assign w_load_mode = i_we ? led_mode_e'(i_mode) : r_mode_reg;
  assign w_load_duty = i_we ? i_duty : r_duty_reg;
`endif

  // Active mode/duty change only at period wrap so a period is never split
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mode_act <= LED_OFF;
      r_duty_act <= '0;
    end else if (i_wrap) begin
      r_mode_act <= w_load_mode;
      r_duty_act <= w_load_duty;
    end
  end

  // Breathe ramp state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dir <= DIR_UP;
      r_lvl <= '0;
      r_div <= '0;
    end else begin
      r_dir <= w_dir_nxt;
      r_lvl <= w_lvl_nxt;
      r_div <= w_div_nxt;
    end
  end

  // Breathe ramp next state: restart on entry, step every BREATHE_DIV wraps,
  // saturate at the ceiling (turn down) and at zero (turn up)
  always_comb begin
    w_dir_nxt = r_dir;
    w_lvl_nxt = r_lvl;
    w_div_nxt = r_div;
    w_lvl_up  = {1'b0, r_lvl} + STEP_EXT;
    w_lvl_dn  = {1'b0, r_lvl} - STEP_EXT;
    if (i_wrap && (w_load_mode == LED_BREATHE)) begin
      if (r_mode_act != LED_BREATHE) begin
        w_lvl_nxt = '0;
        w_dir_nxt = DIR_UP;
        w_div_nxt = '0;
      end else if (r_div != DIV_LAST) begin
        w_div_nxt = r_div + DIV_W'(1);
      end else begin
        w_div_nxt = '0;
        case (r_dir)
          DIR_UP: begin
            if (w_lvl_up >= {1'b0, w_load_duty}) begin
              w_lvl_nxt = w_load_duty;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_lvl_nxt = w_lvl_up[PWM_WIDTH-1:0];
            end
          end
          default: begin
            // Borrow out of the top bit means the step overshot zero
            if (w_lvl_dn[PWM_WIDTH] || (w_lvl_dn == '0)) begin
              w_lvl_nxt = '0;
              w_dir_nxt = DIR_UP;
            end else begin
              w_lvl_nxt = w_lvl_dn[PWM_WIDTH-1:0];
            end
          end
        endcase
      end
    end
  end

  // Decide the LED state for the current counter value
  always_comb begin
    w_on = 1'b0;
    case (r_mode_act)
      LED_ON:      w_on = 1'b1;
      LED_PWM:     w_on = (i_cnt < r_duty_act);
      LED_BREATHE: w_on = (i_cnt < r_lvl);
      default:     w_on = 1'b0;
    endcase
  end

  // Registered LED drive with board polarity applied
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_led <= OFF_LEVEL;
    end else begin
      r_led <= w_on ^ OFF_LEVEL;
    end
  end

  assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_multi
// Description : N-channel PWM LED driver. Owns the shared period counter,
//               the period register, configuration decode and the period
//               tick; each LED is driven by an led_pwm_channel instance.
//               Optional build macro LED_GAMMA_EN selects a quadratic duty
//               curve inside the channels.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_multi
  import led_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int PWM_WIDTH    = 16,
  parameter int BREATHE_DIV  = 64,
  parameter int BREATHE_STEP = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [PWM_WIDTH-1:0]  PERIOD,
  input  logic                  CFG_WE,
  input  logic [3:0]            CFG_CH,
  input  logic [LED_MODE_W-1:0] CFG_MODE,
  input  logic [PWM_WIDTH-1:0]  CFG_DUTY,
  output logic [CHANNELS-1:0]   LEDs,
  output logic                  PERIOD_TICK
);

  logic [PWM_WIDTH-1:0] r_cnt;
  logic [PWM_WIDTH-1:0] r_per_q;
  logic                 r_started;
  logic                 r_tick;
  logic [PWM_WIDTH-1:0] w_per_eff;
  logic                 w_wrap;

  // Before the first period register load, the live PERIOD input is the limit
  assign w_per_eff = r_started ? r_per_q : PERIOD;
  assign w_wrap    = (r_cnt == w_per_eff);

  // Period counter, period register capture and registered wrap tick
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= '0;
      r_per_q   <= '0;
      r_started <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_wrap ? '0 : (r_cnt + PWM_WIDTH'(1));
      r_started <= 1'b1;
      r_tick    <= w_wrap;
      if (w_wrap || !r_started) begin
        r_per_q <= PERIOD;
      end
    end
  end

  assign PERIOD_TICK = r_tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic w_we;

    // Indices at or above CHANNELS match no instance and are dropped
    assign w_we = CFG_WE && (CFG_CH == 4'(g));

    led_pwm_channel #(
      .PWM_WIDTH    (PWM_WIDTH),
      .BREATHE_DIV  (BREATHE_DIV),
      .BREATHE_STEP (BREATHE_STEP),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .CLK    (CLK),
      .nRST   (nRST),
      .i_cnt  (r_cnt),
      .i_wrap (w_wrap),
      .i_we   (w_we),
      .i_mode (CFG_MODE),
      .i_duty (CFG_DUTY),
      .o_led  (LEDs[g])
    );
  end

endmodule
`default_nettype wire
